// File: rtl/inst_queue_pkg.sv
// Shared widths and helpers for the fetch-to-decode instruction queue.
// Bus-width defaults stand in for the InstBus / InstAddrBus widths.
package inst_queue_pkg;
    localparam int INST_BUS_W      = 32;
    localparam int INST_ADDR_BUS_W = 32;

    // Decode can consume at most two entries per cycle; the code 3 saturates to 2.
    function automatic logic [1:0] eff_issue(input logic [1:0] issue);
        return (issue == 2'd3) ? 2'd2 : issue;
    endfunction
endpackage

// File: rtl/inst_queue.sv
// Dual-push / dual-pop circular instruction queue between fetch and decode.
// Outputs are combinational views of the head and head+1 entries.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int INST_W = INST_BUS_W,
    parameter  int ADDR_W = INST_ADDR_BUS_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid1,
    input  logic              in_valid2,
    input  logic [INST_W-1:0] in_inst1,
    input  logic [INST_W-1:0] in_inst2,
    input  logic [ADDR_W-1:0] in_addr1,
    input  logic [ADDR_W-1:0] in_addr2,
    output logic              in_ready,
    output logic              out_valid1,
    output logic              out_valid2,
    output logic [INST_W-1:0] out_inst1,
    output logic [INST_W-1:0] out_inst2,
    output logic [ADDR_W-1:0] out_addr1,
    output logic [ADDR_W-1:0] out_addr2,
    input  logic [1:0]        issue_cnt,
    output logic [CNT_W-1:0]  count
);

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];

    logic [PTR_W-1:0] head, tail, head1, tail1;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic [1:0]       n_push, n_pop, want;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);

    // Room for a full dual push is judged on the registered count only, so a
    // same-cycle pop never opens the gate and the queue can never overflow.
    assign in_ready = (cnt_q <= CNT_W'(DEPTH - 2));
    assign push     = in_ready & in_valid1 & ~flush;
    assign n_push   = push ? (in_valid2 ? 2'd2 : 2'd1) : 2'd0;
    assign want     = eff_issue(issue_cnt);
    assign n_pop    = (CNT_W'(want) > cnt_q) ? cnt_q[1:0] : want;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
        end else begin
            head  <= head + PTR_W'(n_pop);
            tail  <= tail + PTR_W'(n_push);
            cnt_q <= cnt_q + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[tail] <= in_inst1;
            mem_addr[tail] <= in_addr1;
            if (in_valid2) begin
                mem_inst[tail1] <= in_inst2;
                mem_addr[tail1] <= in_addr2;
            end
        end
    end

    assign count      = cnt_q;
    assign out_valid1 = (cnt_q != '0);
    assign out_valid2 = (cnt_q >= CNT_W'(2));
    assign out_inst1  = out_valid1 ? mem_inst[head]  : '0;
    assign out_addr1  = out_valid1 ? mem_addr[head]  : '0;
    assign out_inst2  = out_valid2 ? mem_inst[head1] : '0;
    assign out_addr2  = out_valid2 ? mem_addr[head1] : '0;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a random phase,
// all compared against a queue-based FIFO reference model.
module tb_inst_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
    logic [31:0] in_inst1 = '0, in_inst2 = '0, in_addr1 = '0, in_addr2 = '0;
    logic        in_ready, out_valid1, out_valid2;
    logic [31:0] out_inst1, out_inst2, out_addr1, out_addr2;
    logic [1:0]  issue_cnt = 2'd0;
    logic [3:0]  count;

    inst_queue #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid1(in_valid1), .in_valid2(in_valid2),
        .in_inst1(in_inst1), .in_inst2(in_inst2),
        .in_addr1(in_addr1), .in_addr2(in_addr2),
        .in_ready(in_ready),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_inst1(out_inst1), .out_inst2(out_inst2),
        .out_addr1(out_addr1), .out_addr2(out_addr2),
        .issue_cnt(issue_cnt), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] inst; } ent_t;
    ent_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pc = 32'h1000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n = q.size();
        chk("count",      64'(count),      64'(n));
        chk("in_ready",   64'(in_ready),   64'(n <= DEPTH - 2));
        chk("out_valid1", 64'(out_valid1), 64'(n >= 1));
        chk("out_valid2", 64'(out_valid2), 64'(n >= 2));
        chk("out_inst1",  64'(out_inst1),  64'(n >= 1 ? q[0].inst : 32'h0));
        chk("out_addr1",  64'(out_addr1),  64'(n >= 1 ? q[0].addr : 32'h0));
        chk("out_inst2",  64'(out_inst2),  64'(n >= 2 ? q[1].inst : 32'h0));
        chk("out_addr2",  64'(out_addr2),  64'(n >= 2 ? q[1].addr : 32'h0));
    endtask

    // One clock: drive at posedge+1, check mid-cycle, model the edge.
    task automatic cyc(input logic v1, input logic v2, input logic [1:0] ic, input logic fl,
                       input logic [31:0] i1, input logic [31:0] i2);
        int   pops;
        logic acc;
        in_valid1 = v1; in_valid2 = v2; issue_cnt = ic; flush = fl;
        in_inst1 = i1; in_inst2 = i2; in_addr1 = pc; in_addr2 = pc + 32'd4;
        #4;
        check_outputs();
        if (fl) begin
            q.delete();
        end else begin
            acc  = v1 && (q.size() <= DEPTH - 2);
            pops = (ic == 2'd3) ? 2 : int'(ic);
            if (pops > q.size()) pops = q.size();
            repeat (pops) void'(q.pop_front());
            if (acc) begin
                q.push_back('{addr: pc, inst: i1});
                pc += 32'd4;
                if (v2) begin
                    q.push_back('{addr: pc, inst: i2});
                    pc += 32'd4;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic rcyc(input logic v1, input logic v2, input logic [1:0] ic, input logic fl);
        cyc(v1, v2, ic, fl, $urandom, $urandom);
    endtask

    initial begin
        // Reset state while rst is held.
        #4;
        check_outputs();
        #8 rst = 1'b0;
        @(posedge clk); #1;

        // First dual push becomes visible one cycle later.
        cyc(1, 1, 0, 0, 32'h24010001, 32'h24020002);
        chk("pc1_0x1000", 64'(out_addr1), 64'h1000);
        chk("pc2_0x1004", 64'(out_addr2), 64'h1004);
        rcyc(1, 1, 0, 0);

        // Fill to DEPTH, then a rejected push.
        rcyc(1, 1, 0, 0);
        rcyc(1, 1, 0, 0);
        chk("full_count", 64'(count), 64'd8);
        rcyc(1, 1, 0, 0);
        chk("full_hold", 64'(count), 64'd8);

        // At count 7 a push is refused while two entries pop.
        rcyc(0, 0, 1, 0);
        rcyc(1, 1, 2, 0);
        chk("c7_pop2", 64'(count), 64'd5);

        // Drain with the saturating issue code.
        repeat (4) rcyc(0, 0, 3, 0);

        // Single pushes interleaved with single pops; tail wraps.
        repeat (9) rcyc(1, 0, 1, 0);
        repeat (2) rcyc(0, 0, 1, 0);

        // Flush beats a simultaneous push and pop.
        rcyc(1, 1, 0, 0);
        rcyc(1, 1, 0, 0);
        rcyc(1, 0, 0, 0);
        chk("pre_flush", 64'(count), 64'd5);
        rcyc(1, 1, 2, 1);
        chk("post_flush", 64'(count), 64'd0);

        // Over-issue at count 1 does not underflow.
        rcyc(1, 0, 0, 0);
        rcyc(0, 0, 2, 0);
        chk("no_underflow", 64'(count), 64'd0);
        rcyc(0, 0, 2, 0);

        // Asynchronous reset pulse takes effect before the next edge.
        rcyc(1, 1, 0, 0);
        rcyc(1, 1, 0, 0);
        in_valid1 = 0; in_valid2 = 0; issue_cnt = 0; flush = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cnt", 64'(count), 64'd0);
        chk("async_rst_v1", 64'(out_valid1), 64'd0);
        chk("async_rst_rdy", 64'(in_ready), 64'd1);
        #1 rst = 1'b0;
        q.delete();
        @(posedge clk); #1;

        // Reset held across an edge with a push pending discards it.
        rcyc(1, 1, 0, 0);
        in_valid1 = 1; in_valid2 = 1; in_addr1 = 32'hdead0000; in_addr2 = 32'hdead0004;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        rcyc(1, 0, 0, 0);
        check_outputs();

        // Random phase.
        for (int i = 0; i < 400; i++)
            rcyc(($urandom % 4) != 0, $urandom % 2, 2'($urandom % 4), ($urandom % 32) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
